// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    function automatic logic [BYTE_W-1:0] csum_update(input logic [BYTE_W-1:0] acc,
                                                      input logic [BYTE_W-1:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Big-endian byte-to-word packer with running XOR checksum; flags the byte that completes a word.
module loader_word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic [BYTE_W-1:0] csum
);

    logic [WORD_W-BYTE_W-1:0] shift_r;
    logic [1:0]               cnt_r;
    logic [BYTE_W-1:0]        csum_r;

    // The incoming byte is the LSB of the word it completes, so the word is available combinationally.
    assign word       = {shift_r, byte_in};
    assign word_valid = byte_en && (cnt_r == 2'd3);
    assign csum       = csum_r;

    // Shift register, byte counter and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            cnt_r   <= 2'd0;
            csum_r  <= '0;
        end else if (clear) begin
            shift_r <= '0;
            cnt_r   <= 2'd0;
            csum_r  <= '0;
        end else if (byte_en) begin
            shift_r <= word[WORD_W-BYTE_W-1:0];
            cnt_r   <= cnt_r + 2'd1;
            csum_r  <= csum_update(csum_r, byte_in);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes a checksum-verified image into instruction memory while holding the core.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int HDR_W = HDR_BYTES * BYTE_W;

    loader_state_t      state_r;
    logic [HDR_W-1:0]   n_r;
    logic [ADDR_W:0]    word_cnt_r;
    logic               rx_ready_r;
    logic               imem_we_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic [WORD_W-1:0]  imem_wdata_r;
    logic               cpu_hold_r;
    logic               done_r;
    logic               err_r;

    logic               xfer_s;
    logic               pack_clear_s;
    logic               pack_en_s;
    logic [WORD_W-1:0]  pack_word_s;
    logic               pack_valid_s;
    logic [BYTE_W-1:0]  pack_csum_s;
    logic [HDR_W-1:0]   n_s;
    logic               hdr_bad_s;
    logic               last_word_s;

    assign xfer_s       = rx_valid && rx_ready_r;
    assign pack_clear_s = xfer_s && (state_r == ST_HDR_LO);
    assign pack_en_s    = xfer_s && (state_r == ST_DATA);
    assign n_s          = {n_r[HDR_W-1:BYTE_W], rx_data};
    assign hdr_bad_s    = (n_s == '0) || (32'(n_s) > (32'd1 << ADDR_W));
    // Counter is one bit wider than the address so a full-depth image ends cleanly.
    assign last_word_s  = ((32'(word_cnt_r) + 32'd1) == 32'(n_r));

    loader_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear_s),
        .byte_en    (pack_en_s),
        .byte_in    (rx_data),
        .word       (pack_word_s),
        .word_valid (pack_valid_s),
        .csum       (pack_csum_s)
    );

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            n_r          <= '0;
            word_cnt_r   <= '0;
            rx_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= '0;
            cpu_hold_r   <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_HDR_HI;
                        rx_ready_r <= 1'b1;
                        cpu_hold_r <= 1'b1;
                    end
                end
                ST_HDR_HI: begin
                    if (xfer_s) begin
                        n_r[HDR_W-1:BYTE_W] <= rx_data;
                        state_r             <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (xfer_s) begin
                        n_r[BYTE_W-1:0] <= rx_data;
                        if (hdr_bad_s) begin
                            state_r    <= ST_ERR;
                            err_r      <= 1'b1;
                            rx_ready_r <= 1'b0;
                        end else begin
                            state_r    <= ST_DATA;
                            word_cnt_r <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (pack_valid_s) begin
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= word_cnt_r[ADDR_W-1:0];
                        imem_wdata_r <= pack_word_s;
                        word_cnt_r   <= word_cnt_r + (ADDR_W+1)'(1);
                        if (last_word_s) begin
                            state_r <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer_s) begin
                        rx_ready_r <= 1'b0;
                        if (rx_data == pack_csum_s) begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            state_r <= ST_ERR;
                            err_r   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r    <= ST_HDR_HI;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                        cpu_hold_r <= 1'b1;
                        rx_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rx_ready_r <= 1'b0;
                    cpu_hold_r <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_hold   = cpu_hold_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at stimulus time and popped by a write monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [39:0] expq[$];
    logic [7:0]  fr[$];
    logic [7:0]  nominal[$];
    logic [7:0]  kb;
    logic [31:0] w;
    logic [7:0]  cs;

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        logic [39:0] e;
        if (rst_n && imem_we === 1'b1) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                e = expq.pop_front();
                check("wr_addr", {24'h0, imem_addr}, {24'h0, e[39:32]});
                check("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_ready_timeout: got %b expected 1", rx_ready);
        end else begin
            rx_data  = b;
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        expq.push_back({a, d});
    endtask

    // Sends a frame; with gap>0 each byte is followed by idle cycles, optionally with start pulses.
    task automatic send_frame(input logic [7:0] q[$], input int gap, input bit poke);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i]);
            if (gap > 0 && i != q.size() - 1) begin
                repeat (gap) begin
                    start = poke;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'h0);
        check({tag, "_imem_we"}, {31'h0, imem_we}, 32'h0);
        check({tag, "_imem_addr"}, {24'h0, imem_addr}, 32'h0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'h0);
        check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, 32'h1);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_err"}, {31'h0, err}, 32'h0);
    endtask

    initial begin
        // XOR of 20 08 00 05 00 00 00 0C is 0x21.
        nominal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h21};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("in_reset");
        rst_n = 1'b1;
        idle(2);
        check_reset_values("after_reset");

        // Nominal frame.
        pulse_start();
        check("nom_rx_ready", {31'h0, rx_ready}, 32'h1);
        push_wr(8'h00, 32'h20080005);
        push_wr(8'h01, 32'h0000000C);
        send_frame(nominal, 0, 1'b0);
        check("nom_done", {31'h0, done}, 32'h1);
        check("nom_err", {31'h0, err}, 32'h0);
        check("nom_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        check("nom_rx_ready_off", {31'h0, rx_ready}, 32'h0);
        idle(2);

        // Bad checksum: words still written, core stays held.
        pulse_start();
        check("bad_done_cleared", {31'h0, done}, 32'h0);
        check("bad_hold_raised", {31'h0, cpu_hold}, 32'h1);
        push_wr(8'h00, 32'h20080005);
        push_wr(8'h01, 32'h0000000C);
        fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h2C};
        send_frame(fr, 0, 1'b0);
        check("bad_err", {31'h0, err}, 32'h1);
        check("bad_done", {31'h0, done}, 32'h0);
        check("bad_cpu_hold", {31'h0, cpu_hold}, 32'h1);
        idle(2);

        // N = 0.
        pulse_start();
        check("n0_err_cleared", {31'h0, err}, 32'h0);
        fr = '{8'h00, 8'h00};
        send_frame(fr, 0, 1'b0);
        check("n0_err", {31'h0, err}, 32'h1);
        check("n0_rx_ready", {31'h0, rx_ready}, 32'h0);
        idle(2);

        // N = 257 exceeds depth.
        pulse_start();
        fr = '{8'h01, 8'h01};
        send_frame(fr, 0, 1'b0);
        check("n257_err", {31'h0, err}, 32'h1);
        check("n257_rx_ready", {31'h0, rx_ready}, 32'h0);
        idle(2);

        // N = 256, full depth.
        pulse_start();
        fr = '{8'h01, 8'h00};
        cs = 8'h00;
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            w  = {kb, ~kb, 8'hC3, 8'(k * 3)};
            push_wr(kb, w);
            for (int j = 3; j >= 0; j--) begin
                fr.push_back(w[j*8 +: 8]);
                cs = cs ^ w[j*8 +: 8];
            end
        end
        fr.push_back(cs);
        send_frame(fr, 0, 1'b0);
        check("full_done", {31'h0, done}, 32'h1);
        check("full_err", {31'h0, err}, 32'h0);
        check("full_last_addr", {24'h0, imem_addr}, 32'h000000FF);
        idle(2);

        // Gapped stream with stray start pulses.
        pulse_start();
        push_wr(8'h00, 32'h20080005);
        push_wr(8'h01, 32'h0000000C);
        send_frame(nominal, 2, 1'b1);
        check("gap_done", {31'h0, done}, 32'h1);
        check("gap_err", {31'h0, err}, 32'h0);
        check("gap_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        idle(2);

        // Reset after the 6th payload byte.
        pulse_start();
        push_wr(8'h00, 32'h20080005);
        fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
        send_frame(fr, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        check("post_reset_idle_ready", {31'h0, rx_ready}, 32'h0);
        pulse_start();
        push_wr(8'h00, 32'h20080005);
        push_wr(8'h01, 32'h0000000C);
        send_frame(nominal, 0, 1'b0);
        check("post_reset_done", {31'h0, done}, 32'h1);
        idle(2);

        // Reload after DONE.
        pulse_start();
        check("reload_done_cleared", {31'h0, done}, 32'h0);
        check("reload_hold", {31'h0, cpu_hold}, 32'h1);
        push_wr(8'h00, 32'h00000008);
        fr = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08};
        send_frame(fr, 0, 1'b0);
        check("reload_done", {31'h0, done}, 32'h1);
        check("reload_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        idle(3);

        check("writes_outstanding", expq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
